vga_frame_sequencer: RTL

Generates 640x480@60 VGA timing from the 100 MHz system clock and arbitrates the game-logic update window. Contains a pixel-clock-enable divider, the horizontal and vertical counters, sync and visible-area decode, and a request/grant handshake. The handshake lets the Pong game logic modify ball and paddle registers only during vertical blanking. The block sits between the system clock and both the colour generator and the game-state logic.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_frame_sequencer_if.sv | 12 +
 rtl/vga_update_arbiter.sv | 77 +++++++
 rtl/vga_frame_sequencer.sv | 110 +++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and update-arbiter state type.
package vga_pkg;

  // Default 640x480@60 timing, 100 MHz system clock
  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;

  localparam int unsigned H_TOTAL     = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int unsigned V_TOTAL     = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
  localparam int unsigned H_VIS_START = H_SYNC + H_BACK;
  localparam int unsigned V_VIS_START = V_SYNC + V_BACK;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    USED
  } upd_state_t;

endpackage

// File: rtl/vga_frame_sequencer_if.sv
// Game-logic update-window handshake between sequencer and game state.
interface vga_frame_sequencer_if;
  logic upd_req;
  logic upd_done;
  logic upd_grant;
  logic upd_overrun;

  // Game logic side
  modport master (output upd_req, output upd_done, input upd_grant, input upd_overrun);
  // Sequencer side
  modport slave (input upd_req, input upd_done, output upd_grant, output upd_overrun);
endinterface

// File: rtl/vga_update_arbiter.sv
// Grants the game logic one update window per frame during vertical blanking.
// Optional: define VGA_OVERRUN_DET_EN to flag a window that closes on a held grant.
module vga_update_arbiter
  import vga_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic win_open,
  input  logic win_close,
  input  logic upd_req,
  input  logic upd_done,
  output logic upd_grant,
  output logic upd_overrun
);

  upd_state_t state_q;
  logic       win_q;
  logic       in_window;

`ifdef VGA_OVERRUN_DET_EN
  logic overrun_q;
  assign upd_overrun = overrun_q;
`else
  assign upd_overrun = 1'b0;
`endif

  // Window level: the counters reset to (0,0), which is inside the window
  assign in_window = (win_q | win_open) & ~win_close;

  // Arbiter FSM with registered grant and sticky overrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      win_q     <= 1'b1;
      upd_grant <= 1'b0;
`ifdef VGA_OVERRUN_DET_EN
      overrun_q <= 1'b0;
`endif
    end else begin
      if (win_open) begin
        win_q <= 1'b1;
      end else if (win_close) begin
        win_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (in_window && upd_req) begin
            state_q   <= GRANT;
            upd_grant <= 1'b1;
          end
        end
        GRANT: begin
          if (win_close || upd_done || !upd_req) begin
            state_q   <= USED;
            upd_grant <= 1'b0;
          end
`ifdef VGA_OVERRUN_DET_EN
          // A done arriving on the closing clk still counts as on time
          if (win_close && !upd_done) begin
            overrun_q <= 1'b1;
          end
`endif
        end
        USED: begin
          if (win_close) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          upd_grant <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/vga_frame_sequencer.sv
// VGA timing generator with pixel-enable divider, sync/visible decode and
// vertical-blanking update arbiter. Optional macro: VGA_OVERRUN_DET_EN.
module vga_frame_sequencer #(
  parameter int unsigned CLK_DIV   = vga_pkg::CLK_DIV,
  parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK    = vga_pkg::H_BACK,
  parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
  parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_pkg::V_BACK,
  parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        pix_en,
  output logic                        Hsync,
  output logic                        Vsync,
  output logic                        video_on,
  output logic [9:0]                  pixel_x,
  output logic [9:0]                  pixel_y,
  output logic                        frame_start,
  vga_frame_sequencer_if.slave        upd
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  localparam logic [9:0] HMax      = 10'(H_SYNC + H_BACK + H_VISIBLE + H_FRONT - 1);
  localparam logic [9:0] HSyncEnd  = 10'(H_SYNC);
  localparam logic [9:0] HVisStart = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] HVisEnd   = 10'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [9:0] VMax      = 10'(V_SYNC + V_BACK + V_VISIBLE + V_FRONT - 1);
  localparam logic [9:0] VSyncEnd  = 10'(V_SYNC);
  localparam logic [9:0] VVisStart = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] VVisEnd   = 10'(V_SYNC + V_BACK + V_VISIBLE);

  logic [DivW-1:0] div_q;
  logic [9:0]      h_q, v_q, h_d, v_d;
  logic            vis_d;
  logic            win_open_q, win_close_q;

  // Pixel-clock-enable divider; pix_en follows the terminal count by one clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      pix_en <= 1'b0;
    end else begin
      div_q  <= (div_q == DivMax) ? '0 : div_q + 1'b1;
      pix_en <= (div_q == DivMax);
    end
  end

  // Next raster position
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en) begin
      if (h_q == HMax) begin
        h_d = '0;
        v_d = (v_q == VMax) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  assign vis_d = (h_d >= HVisStart) && (h_d < HVisEnd) && (v_d >= VVisStart) && (v_d < VVisEnd);

  // Counters and outputs decoded from the next position so they move together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q         <= '0;
      v_q         <= '0;
      Hsync       <= SYNC_POL;
      Vsync       <= SYNC_POL;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
      win_open_q  <= 1'b0;
      win_close_q <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      Hsync       <= (h_d < HSyncEnd) ? SYNC_POL : ~SYNC_POL;
      Vsync       <= (v_d < VSyncEnd) ? SYNC_POL : ~SYNC_POL;
      video_on    <= vis_d;
      pixel_x     <= vis_d ? h_d - HVisStart : '0;
      pixel_y     <= vis_d ? v_d - VVisStart : '0;
      // h_d == 0 under pix_en only on a line wrap, so these are one-clk strobes
      frame_start <= pix_en && (h_d == '0) && (v_d == '0);
      win_open_q  <= pix_en && (h_d == '0) && (v_d == VVisEnd);
      win_close_q <= pix_en && (h_d == '0) && (v_d == VVisStart);
    end
  end

  vga_update_arbiter u_arbiter (
    .clk         (clk),
    .rst         (rst),
    .win_open    (win_open_q),
    .win_close   (win_close_q),
    .upd_req     (upd.upd_req),
    .upd_done    (upd.upd_done),
    .upd_grant   (upd.upd_grant),
    .upd_overrun (upd.upd_overrun)
  );

endmodule
